// File: rtl/fp_exception_pipe_pkg.sv
// fp_exception_pipe_pkg: operand classes and format constants shared by the exception pipe
package fp_exception_pipe_pkg;
    typedef enum logic [1:0] {CLS_NORMAL, CLS_ZERO, CLS_INF, CLS_NAN} fp_class_e;
    localparam int HALF_EXP_W = 5;
    localparam int HALF_MANT_W = 10;
    localparam int SINGLE_EXP_W = 8;
    localparam int SINGLE_MANT_W = 23;
    localparam logic [63:0] CANON_NAN_MANT = '1;
endpackage

// File: rtl/fp_classify.sv
// fp_classify: combinational NaN/INF/ZERO/NORMAL classification of one operand
module fp_classify
    import fp_exception_pipe_pkg::*;
#(
    parameter int EXP_W = HALF_EXP_W,
    parameter int MANT_W = HALF_MANT_W
) (
    input  logic [EXP_W-1:0]  exp,
    input  logic [MANT_W-1:0] mant,
    output fp_class_e         cls
);
    // all-ones exponent splits on mantissa; zero needs both fields clear
    always_comb begin
        cls = (&exp) ? ((|mant) ? CLS_NAN : CLS_INF) : (exp == '0 && mant == '0) ? CLS_ZERO : CLS_NORMAL;
    end
endmodule

// File: rtl/fp_exception_pipe.sv
// fp_exception_pipe: two-stage special-case resolver for FP add/sub with saturating exception counter
module fp_exception_pipe
    import fp_exception_pipe_pkg::*;
#(
    parameter int EXP_W = HALF_EXP_W,
    parameter int MANT_W = HALF_MANT_W,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     op_sub,
    input  logic                     sign_a,
    input  logic                     sign_b,
    input  logic [EXP_W-1:0]         exp_a,
    input  logic [EXP_W-1:0]         exp_b,
    input  logic [MANT_W-1:0]        mant_a,
    input  logic [MANT_W-1:0]        mant_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MANT_W:0]    q,
    output logic                     is_exception,
    output logic                     flag_invalid,
    output logic [CNT_W-1:0]         exc_count,
    input  logic                     clr_count
);
    localparam int W = 1 + EXP_W + MANT_W;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    fp_class_e cls_a, cls_b, s1_cls_a, s1_cls_b;
    logic s1_valid, s1_sign_a, s1_sign_b;
    logic [EXP_W-1:0] s1_exp_a, s1_exp_b;
    logic [MANT_W-1:0] s1_mant_a, s1_mant_b, min_mant;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [W-1:0] q_n, op_a, op_b;
    logic exc_n, inv_n;

    fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_a (.exp(exp_a), .mant(mant_a), .cls(cls_a));
    fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_b (.exp(exp_b), .mant(mant_b), .cls(cls_b));

    assign in_ready = !out_valid || out_ready;

    // stage 1: capture classes and operands, with the effective sign of B folded in
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cls_a <= CLS_NORMAL;
            s1_cls_b <= CLS_NORMAL;
            s1_sign_a <= 1'b0;
            s1_sign_b <= 1'b0;
            s1_exp_a <= '0;
            s1_exp_b <= '0;
            s1_mant_a <= '0;
            s1_mant_b <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            s1_cls_a <= cls_a;
            s1_cls_b <= cls_b;
            s1_sign_a <= sign_a;
            s1_sign_b <= sign_b ^ op_sub;
            s1_exp_a <= exp_a;
            s1_exp_b <= exp_b;
            s1_mant_a <= mant_a;
            s1_mant_b <= mant_b;
        end
    end

    // first matching special-case rule decides the result; no match means the adder must handle it
    always_comb begin
        a_nan = s1_cls_a == CLS_NAN;
        b_nan = s1_cls_b == CLS_NAN;
        a_inf = s1_cls_a == CLS_INF;
        b_inf = s1_cls_b == CLS_INF;
        a_zero = s1_cls_a == CLS_ZERO;
        b_zero = s1_cls_b == CLS_ZERO;
        op_a = {s1_sign_a, s1_exp_a, s1_mant_a};
        op_b = {s1_sign_b, s1_exp_b, s1_mant_b};
        min_mant = (s1_mant_b < s1_mant_a) ? s1_mant_b : s1_mant_a;
        q_n = (a_nan && b_nan) ? {s1_sign_a, EXP_ONES, min_mant} :
              a_nan ? op_a :
              b_nan ? op_b :
              (a_inf && b_inf) ? ((s1_sign_a == s1_sign_b) ? {s1_sign_a, EXP_ONES, {MANT_W{1'b0}}}
                                                           : {1'b0, EXP_ONES, CANON_NAN_MANT[MANT_W-1:0]}) :
              a_inf ? op_a :
              b_inf ? {s1_sign_b, EXP_ONES, {MANT_W{1'b0}}} :
              a_zero ? op_b :
              b_zero ? op_a : '0;
        inv_n = a_inf && b_inf && (s1_sign_a != s1_sign_b);
        exc_n = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
    end

    // stage 2: register result and flags, holding everything while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            q <= '0;
            is_exception <= 1'b0;
            flag_invalid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= s1_valid;
            q <= q_n;
            is_exception <= exc_n;
            flag_invalid <= inv_n;
        end
    end

    // count delivered exceptions, saturating; clear wins over a same-cycle delivery
    always_ff @(posedge clk) begin
        if (rst || clr_count)
            exc_count <= '0;
        else if (out_valid && out_ready && is_exception && !(&exc_count))
            exc_count <= exc_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_fp_exception_pipe.sv
// tb_fp_exception_pipe: directed vector table plus stall, saturation, clear and reset sequences
module tb_fp_exception_pipe;
    import fp_exception_pipe_pkg::*;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic        exc;
        logic        inv;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];
    int n_tests = 0;
    int n_fail = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic op_sub = 1'b0;
    logic clr_count = 1'b0;
    logic [15:0] ha = '0, hb = '0;
    logic [31:0] s_a = '0, s_b = '0;

    logic in_ready, out_valid, is_exception, flag_invalid;
    logic [15:0] q;
    logic [15:0] exc_count;
    logic c2_ir, c2_ov, c2_exc, c2_inv;
    logic [15:0] c2_q;
    logic [1:0] c2_count;
    logic s_ir, s_ov, s_exc, s_inv;
    logic [31:0] s_q;
    logic [15:0] s_count;

    always #5 clk = ~clk;

    fp_exception_pipe #(.EXP_W(5), .MANT_W(10), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
        .sign_a(ha[15]), .sign_b(hb[15]), .exp_a(ha[14:10]), .exp_b(hb[14:10]),
        .mant_a(ha[9:0]), .mant_b(hb[9:0]), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .is_exception(is_exception), .flag_invalid(flag_invalid),
        .exc_count(exc_count), .clr_count(clr_count)
    );

    fp_exception_pipe #(.EXP_W(5), .MANT_W(10), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c2_ir), .op_sub(op_sub),
        .sign_a(ha[15]), .sign_b(hb[15]), .exp_a(ha[14:10]), .exp_b(hb[14:10]),
        .mant_a(ha[9:0]), .mant_b(hb[9:0]), .out_valid(c2_ov), .out_ready(out_ready),
        .q(c2_q), .is_exception(c2_exc), .flag_invalid(c2_inv),
        .exc_count(c2_count), .clr_count(clr_count)
    );

    fp_exception_pipe #(.EXP_W(SINGLE_EXP_W), .MANT_W(SINGLE_MANT_W), .CNT_W(16)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_ir), .op_sub(op_sub),
        .sign_a(s_a[31]), .sign_b(s_b[31]), .exp_a(s_a[30:23]), .exp_b(s_b[30:23]),
        .mant_a(s_a[22:0]), .mant_b(s_b[22:0]), .out_valid(s_ov), .out_ready(out_ready),
        .q(s_q), .is_exception(s_exc), .flag_invalid(s_inv),
        .exc_count(s_count), .clr_count(clr_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        clr_count = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_q", {16'd0, q}, 32'd0);
        chk("rst_flags", {30'd0, is_exception, flag_invalid}, 32'd0);
        chk("rst_count", {16'd0, exc_count}, 32'd0);
        chk("rst_in_ready", {29'd0, in_ready, c2_ir, s_ir}, 32'd7);
        chk("rst_c2", {29'd0, c2_ov, c2_count}, 32'd0);
    endtask

    task automatic set_ops(input int i);
        op_sub = vecs[i].op;
        ha = vecs[i].a;
        hb = vecs[i].b;
    endtask

    task automatic apply_vec(input int i);
        set_ops(i);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
        chk($sformatf("vec%0d_q", i), {16'd0, q}, {16'd0, vecs[i].q});
        chk($sformatf("vec%0d_flags", i), {30'd0, is_exception, flag_invalid}, {30'd0, vecs[i].exc, vecs[i].inv});
        chk($sformatf("vec%0d_c2", i), {13'd0, c2_ov, c2_exc, c2_inv, c2_q}, {13'd0, 1'b1, vecs[i].exc, vecs[i].inv, vecs[i].q});
    endtask

    initial begin
        int sv[4];
        int sent, got, stalls;
        vecs[0]  = '{1'b0, 16'h7E00, 16'h7C01, 16'h7C01, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 16'h7C00, 16'hFC00, 16'h7FFF, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 16'h7C00, 16'h7C00, 16'h7FFF, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 16'h0000, 16'h3C00, 16'hBC00, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 16'h3C00, 16'h4000, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 16'h7C00, 16'h7C00, 16'h7C00, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 16'hFC00, 16'h7C00, 16'hFC00, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 16'h7C05, 16'h3C00, 16'h7C05, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 16'h3C00, 16'hFE01, 16'h7E01, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 16'h3C00, 16'h7C00, 16'hFC00, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 16'hC000, 16'h8000, 16'hC000, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 16'h7C00, 16'h4000, 16'h7C00, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 16'hFD00, 16'h7D00, 16'hFD00, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 16'h3555, 16'h2AAA, 16'h0000, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < NV; i++) apply_vec(i);
        step();
        chk("table_count", {16'd0, exc_count}, 32'd13);
        chk("table_count_sat", {30'd0, c2_count}, 32'd3);

        do_reset();
        sv = '{0, 1, 3, 5};
        sent = 0;
        got = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            out_ready = !(got == 1 && out_valid && stalls < 3);
            #1;
            if (!out_ready) begin
                stalls++;
                chk("stall_q", {16'd0, q}, {16'd0, vecs[sv[1]].q});
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            end else if (out_valid) begin
                chk($sformatf("stream%0d_q", got), {16'd0, q}, {16'd0, vecs[sv[got]].q});
                got++;
            end
            in_valid = sent < 4;
            if (sent < 4) set_ops(sv[sent]);
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_delivered", got, 32'd4);
        chk("stream_stalls", stalls, 32'd3);
        chk("stream_count", {16'd0, exc_count}, 32'd4);

        do_reset();
        apply_vec(0);
        apply_vec(1);
        apply_vec(2);
        apply_vec(3);
        apply_vec(5);
        step();
        chk("sat_count16", {16'd0, exc_count}, 32'd5);
        chk("sat_count2", {30'd0, c2_count}, 32'd3);
        apply_vec(0);
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        chk("clr_count16", {16'd0, exc_count}, 32'd0);
        chk("clr_count2", {30'd0, c2_count}, 32'd0);

        do_reset();
        op_sub = 1'b0;
        ha = '0;
        hb = '0;
        s_a = 32'h7F800000;
        s_b = 32'h3F800000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("single_valid", {31'd0, s_ov}, 32'd1);
        chk("single_q", s_q, 32'h7F800000);
        chk("single_flags", {30'd0, s_exc, s_inv}, 32'd2);
        s_a = 32'hFF800000;
        s_b = 32'h7F800000;
        in_valid = 1'b1;
        step();
        s_a = 32'h00000000;
        s_b = 32'h40000000;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", {30'd0, s_ov, out_valid}, 32'd0);
        chk("midrst_ready", {31'd0, s_ir}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("midrst_quiet%0d", i), {30'd0, s_ov, out_valid}, 32'd0);
        end
        chk("midrst_count", {16'd0, s_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_exception_pipe.md
FP_EXCEPTION_PIPE -- requirements
Module: fp_exception_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent width.
REQ-002 SHALL have parameter MANT_W, default 10, mantissa width; W = 1+EXP_W+MANT_W.
REQ-003 SHALL have parameter CNT_W, default 16, exception counter width.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 IN_VALID  input  1  operand pair valid.
REQ-007 IN_READY  output  1  block accepts operands this cycle.
REQ-008 OP_SUB  input  1  1 = A-B (B sign inverted), 0 = A+B.
REQ-009 SIGN_A, SIGN_B  input  1 each  operand signs.
REQ-010 EXP_A, EXP_B  input  EXP_W each  biased exponents.
REQ-011 MANT_A, MANT_B  input  MANT_W each  fraction fields.
REQ-012 OUT_VALID  output  1  result valid.
REQ-013 OUT_READY  input  1  downstream accepts result.
REQ-014 Q  output  W  special-case result {sign, exp, mant}.
REQ-015 IS_EXCEPTION  output  1  Q is final; normal adder path not needed.
REQ-016 FLAG_INVALID  output  1  inf-inf of opposite effective sign.
REQ-017 EXC_COUNT  output  CNT_W  saturating count of delivered exceptions.
REQ-018 CLR_COUNT  input  1  synchronous clear of EXC_COUNT.

Function
REQ-019 Effective sign SB = SIGN_B XOR OP_SUB SHALL replace SIGN_B in all rules.
REQ-020 Classes: NaN = exp all-ones, mant!=0; INF = exp all-ones, mant==0; ZERO = exp==0, mant==0.
REQ-021 Priority, first match wins: both NaN -> {SIGN_A, ones, min(MANT_A,MANT_B) unsigned, tie -> MANT_A}; A NaN -> A; B NaN -> {SB,EXP_B,MANT_B}; both INF -> same sign {SIGN_A,ones,0} else {0,ones,all-ones} with FLAG_INVALID=1; A INF -> A; B INF -> {SB,ones,0}; A ZERO -> {SB,EXP_B,MANT_B}; B ZERO -> A.
REQ-022 No rule matched: IS_EXCEPTION=0, Q=0, FLAG_INVALID=0.
REQ-023 Two-stage pipeline: stage 1 registers classification bits and operands, stage 2 registers Q/flags; latency 2 cycles from accepted input to OUT_VALID with no stall.
REQ-024 Input accepted when IN_VALID && IN_READY; output delivered when OUT_VALID && OUT_READY.
REQ-025 IN_READY = !OUT_VALID || OUT_READY (whole-pipe stall, combinational); throughput one pair per cycle.
REQ-026 On stall (OUT_VALID && !OUT_READY) all stage registers SHALL hold; Q, flags stable until delivered.
REQ-027 Stage bubbles (valid=0) SHALL propagate; no result emitted for cycles without accepted input.
REQ-028 EXC_COUNT SHALL increment on delivery with IS_EXCEPTION=1, saturate at all-ones.
REQ-029 CLR_COUNT SHALL take priority over simultaneous increment (result 0).

Reset
REQ-030 RST SHALL clear both stage valids, OUT_VALID=0, Q=0, IS_EXCEPTION=0, FLAG_INVALID=0, EXC_COUNT=0.
REQ-031 RST mid-operation SHALL discard in-flight pairs; none delivered after reset.
REQ-032 IN_READY SHALL be 1 in the cycle after reset deasserts.

Structure
REQ-033 Shared package SHALL hold class encoding (NORMAL, ZERO, INF, NAN), canonical-NaN mantissa constant, half/single format constants (5/10, 8/23).
REQ-034 One sub-module fp_classify (EXP_W, MANT_W parametrised, combinational) SHALL be instantiated once per operand in stage 1.

Verification
REQ-035 Half, A=0x7E00, B=0x7C01, ADD -> after 2 cycles Q=0x7C01, IS_EXCEPTION=1, FLAG_INVALID=0.
REQ-036 A=0x7C00, B=0xFC00, ADD -> Q=0x7FFF, FLAG_INVALID=1; same A,B=0x7C00 with OP_SUB=1 -> Q=0x7FFF, FLAG_INVALID=1.
REQ-037 A=0x0000, B=0x3C00, OP_SUB=1 -> Q=0xBC00, IS_EXCEPTION=1; A=0x3C00, B=0x4000 -> Q=0x0000, IS_EXCEPTION=0.
REQ-038 Stream 4 exception pairs, OUT_READY low 3 cycles on 2nd -> Q held, IN_READY=0 while stalled, all 4 delivered in order, EXC_COUNT=4.
REQ-039 CNT_W=2, deliver 5 exceptions -> EXC_COUNT=3; CLR_COUNT with simultaneous delivery -> 0.
REQ-040 Single (EXP_W=8, MANT_W=23): A=0x7F800000, B=0x3F800000 -> Q=0x7F800000; RST asserted with 2 pairs in flight -> OUT_VALID=0, no later delivery.
